rom_load_sequencer: RTL and testbench

Sequences the HPS ROM download stream into the Pac-Man core's ROM and PROM stores. It decodes each downloaded byte into a target region and rebases its address. A 2-entry skid FIFO absorbs downloaded bytes while the target store is not ready. The block keeps the core in reset for the whole download and for a fixed settle window afterwards. It sits between `hps_io`'s ioctl outputs and the `pacman` core's download and `RESET` inputs.

---
 rtl/rom_load_sequencer.sv | 102 ++++++++++
 tb/tb_rom_load_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer: routes the HPS ROM download into Pac-Man ROM/PROM stores through a 2-entry skid FIFO and holds the core in reset around it
module rom_load_sequencer #(
  parameter logic [15:0] PROG_END    = 16'h4000,
  parameter logic [15:0] GFX_END     = 16'h6000,
  parameter logic [15:0] PROM_END    = 16'h6140,
  parameter int          HOLD_CYCLES = 256
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        dn_download,
  input  logic        dn_wr,
  input  logic [15:0] dn_addr,
  input  logic [7:0]  dn_data,
  input  logic        wr_ready,
  output logic        rom_we,
  output logic [1:0]  rom_sel,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        core_reset,
  output logic        busy,
  output logic        err_ovf,
  output logic        err_range,
  output logic [15:0] byte_count
);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, HOLD} state_t;
  localparam logic [15:0] HOLD_INIT = 16'(HOLD_CYCLES - 1);
  state_t      state;
  logic [15:0] hold_cnt;
  logic        dl_q, dl_p, rise;
  logic [25:0] e0, e1, entry;
  logic [1:0]  cnt, cnt_nxt, sel;
  logic [15:0] base;
  logic        in_range, wr_ok, push, pop, ovf, rng;
  // region decode and address rebase of the incoming byte
  always_comb begin
    sel      = dn_addr < PROG_END ? 2'd0 : dn_addr < GFX_END ? 2'd1 : 2'd2;
    base     = dn_addr < PROG_END ? 16'h0000 : dn_addr < GFX_END ? PROG_END : GFX_END;
    in_range = dn_addr < PROM_END;
    entry    = {sel, dn_addr - base, dn_data};
  end
  assign rise       = dl_q & ~dl_p;
  assign rom_we     = cnt != 2'd0;
  assign {rom_sel, rom_addr, rom_data} = e0;
  assign pop        = rom_we & wr_ready;
  assign wr_ok      = dn_wr & dn_download;
  assign push       = wr_ok & in_range & (cnt != 2'd2 | pop);
  assign ovf        = wr_ok & in_range & cnt == 2'd2 & ~pop;
  assign rng        = wr_ok & ~in_range;
  assign cnt_nxt    = cnt + 2'(push) - 2'(pop);
  assign core_reset = state != IDLE;
  assign busy       = state != IDLE;
  // skid FIFO: e0 is the head and drives the write port directly
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      cnt <= 2'd0;
      e0  <= '0;
      e1  <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (pop & cnt == 2'd2) e0 <= e1;
      else if (push & (cnt == 2'd0 | pop)) e0 <= entry;
      if (push & cnt_nxt == 2'd2) e1 <= entry;
    end
  end
  // sticky error flags and accepted-byte counter, restarted on each download
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      err_ovf    <= 1'b0;
      err_range  <= 1'b0;
      byte_count <= 16'h0000;
    end else if (rise) begin
      err_ovf    <= ovf;
      err_range  <= rng;
      byte_count <= 16'(push);
    end else begin
      err_ovf    <= err_ovf | ovf;
      err_range  <= err_range | rng;
      byte_count <= byte_count + 16'(push & byte_count != 16'hFFFF);
    end
  end
  // download sequencing and post-download reset hold
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state    <= HOLD;
      hold_cnt <= HOLD_INIT;
      dl_q     <= 1'b0;
      dl_p     <= 1'b0;
    end else begin
      dl_q <= dn_download;
      dl_p <= dl_q;
      if (rise) state <= LOAD;
      else if (state == LOAD && !dl_q) state <= DRAIN;
      else if (state == DRAIN && cnt_nxt == 2'd0) begin
        state    <= HOLD;
        hold_cnt <= HOLD_INIT;
      end else if (state == HOLD) begin
        if (hold_cnt == 16'h0000) state <= IDLE;
        else hold_cnt <= hold_cnt - 16'h0001;
      end
    end
  end
endmodule

// File: tb/tb_rom_load_sequencer.sv
// tb_rom_load_sequencer: vector table, directed corner sequences and a queue-model random run
module tb_rom_load_sequencer;
  localparam int HOLD = 256;
  logic        clk_sys = 1'b0;
  logic        RESET = 1'b1;
  logic        dn_download = 1'b0, dn_wr = 1'b0, wr_ready = 1'b0;
  logic [15:0] dn_addr = '0;
  logic [7:0]  dn_data = '0;
  logic        rom_we, core_reset, busy, err_ovf, err_range;
  logic [1:0]  rom_sel;
  logic [15:0] rom_addr, byte_count;
  logic [7:0]  rom_data;
  int          total = 0, bad = 0;
  logic [25:0] log_q[$];
  logic [25:0] mq[$];
  logic        m_ovf, m_rng;
  logic [15:0] m_cnt;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        we;
    logic [1:0]  sel;
    logic [15:0] ra;
  } vec_t;
  vec_t v[9];

  rom_load_sequencer dut (
    .clk_sys(clk_sys), .RESET(RESET), .dn_download(dn_download), .dn_wr(dn_wr),
    .dn_addr(dn_addr), .dn_data(dn_data), .wr_ready(wr_ready), .rom_we(rom_we),
    .rom_sel(rom_sel), .rom_addr(rom_addr), .rom_data(rom_data), .core_reset(core_reset),
    .busy(busy), .err_ovf(err_ovf), .err_range(err_range), .byte_count(byte_count)
  );

  always #5 clk_sys = ~clk_sys;

  // record every write the store actually takes
  always @(posedge clk_sys) if (rom_we && wr_ready) log_q.push_back({rom_sel, rom_addr, rom_data});

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
  endtask

  function automatic logic [25:0] ent(input logic [15:0] a, input logic [7:0] d);
    if (a < 16'h4000) return {2'd0, a, d};
    if (a < 16'h6000) return {2'd1, 16'(a - 16'h4000), d};
    return {2'd2, 16'(a - 16'h6000), d};
  endfunction

  task automatic wr_byte(input logic [15:0] a, input logic [7:0] d);
    dn_wr = 1'b1; dn_addr = a; dn_data = d;
    tick();
    dn_wr = 1'b0;
  endtask

  task automatic hold_len(input string nm);
    int n = 0;
    while (core_reset === 1'b1 && n < 400) begin n++; tick(); end
    chk(nm, n, HOLD);
    chk({nm, "_busy"}, busy, 0);
  endtask

  task automatic drain_to_hold();
    int n = 0;
    wr_ready = 1'b0;
    wr_byte(16'h0010, 8'hA5);
    dn_download = 1'b0;
    repeat (4) tick();
    chk("drain_pending", rom_we, 1);
    wr_ready = 1'b1;
    while (rom_we && n < 20) begin n++; tick(); end
    chk("drain_pop", n, 1);
  endtask

  task automatic restart();
    dn_download = 1'b0;
    repeat (2) tick();
    dn_download = 1'b1;
    repeat (3) tick();
  endtask

  task automatic model_check();
    chk("rnd_we", rom_we, mq.size() != 0);
    if (mq.size() != 0) chk("rnd_head", {rom_sel, rom_addr, rom_data}, mq[0]);
    chk("rnd_ovf", err_ovf, m_ovf);
    chk("rnd_rng", err_range, m_rng);
    chk("rnd_cnt", byte_count, m_cnt);
  endtask

  task automatic model_step();
    if (mq.size() != 0 && wr_ready) void'(mq.pop_front());
    if (dn_wr && dn_download) begin
      if (dn_addr >= 16'h6140) m_rng = 1'b1;
      else if (mq.size() < 2) begin
        mq.push_back(ent(dn_addr, dn_data));
        if (m_cnt != 16'hFFFF) m_cnt++;
      end else m_ovf = 1'b1;
    end
  endtask

  initial begin
    int   exp_cnt;
    logic exp_rng, low;
    v[0] = '{16'h0000, 8'h11, 1, 2'd0, 16'h0000};
    v[1] = '{16'h3FFF, 8'h12, 1, 2'd0, 16'h3FFF};
    v[2] = '{16'h4000, 8'h13, 1, 2'd1, 16'h0000};
    v[3] = '{16'h6005, 8'h14, 1, 2'd2, 16'h0005};
    v[4] = '{16'h6140, 8'h15, 0, 2'd0, 16'h0000};
    v[5] = '{16'h5FFF, 8'h16, 1, 2'd1, 16'h1FFF};
    v[6] = '{16'h6000, 8'h17, 1, 2'd2, 16'h0000};
    v[7] = '{16'h613F, 8'h18, 1, 2'd2, 16'h013F};
    v[8] = '{16'hFFFF, 8'h19, 0, 2'd0, 16'h0000};

    repeat (3) tick();
    chk("rst_core_reset", core_reset, 1);
    chk("rst_busy", busy, 1);
    chk("rst_we", rom_we, 0);
    chk("rst_port", {rom_sel, rom_addr, rom_data}, 0);
    chk("rst_flags", {err_ovf, err_range}, 0);
    chk("rst_count", byte_count, 0);
    RESET = 1'b0;
    hold_len("reset_hold");

    dn_download = 1'b1;
    repeat (3) tick();
    chk("load_core_reset", core_reset, 1);
    exp_cnt = 0; exp_rng = 1'b0;
    wr_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wr_byte(v[i].a, v[i].d);
      chk($sformatf("vec%0d_we", i), rom_we, v[i].we);
      if (v[i].we) chk($sformatf("vec%0d_port", i), {rom_sel, rom_addr, rom_data}, {v[i].sel, v[i].ra, v[i].d});
      tick();
      chk($sformatf("vec%0d_idle", i), rom_we, 0);
      exp_cnt += int'(v[i].we);
      exp_rng |= !v[i].we;
      chk($sformatf("vec%0d_count", i), byte_count, exp_cnt);
      chk($sformatf("vec%0d_range", i), err_range, exp_rng);
    end

    drain_to_hold();
    low = 1'b0;
    repeat (10) begin low |= !core_reset; tick(); end
    dn_download = 1'b1;
    repeat (3) begin low |= !core_reset; tick(); end
    chk("restart_core_reset_high", low, 0);
    chk("restart_range_clr", err_range, 0);
    chk("restart_count_clr", byte_count, 0);

    log_q.delete();
    wr_ready = 1'b0;
    wr_byte(16'h0100, 8'h21);
    wr_byte(16'h4100, 8'h22);
    wr_byte(16'h6100, 8'h23);
    chk("bp_ovf", err_ovf, 1);
    chk("bp_head", {rom_we, rom_sel, rom_addr, rom_data}, {1'b1, 2'd0, 16'h0100, 8'h21});
    wr_ready = 1'b1;
    repeat (5) tick();
    chk("bp_writes", log_q.size(), 2);
    chk("bp_w0", log_q.size() > 0 ? log_q[0] : 26'h3FFFFFF, {2'd0, 16'h0100, 8'h21});
    chk("bp_w1", log_q.size() > 1 ? log_q[1] : 26'h3FFFFFF, {2'd1, 16'h0100, 8'h22});
    chk("bp_count", byte_count, 2);

    restart();
    chk("rs_ovf_clr", err_ovf, 0);
    log_q.delete();
    wr_ready = 1'b0;
    wr_byte(16'h0001, 8'h44);
    wr_byte(16'h4002, 8'h55);
    wr_ready = 1'b1;
    wr_byte(16'h6003, 8'h66);
    repeat (4) tick();
    chk("pp_ovf", err_ovf, 0);
    chk("pp_writes", log_q.size(), 3);
    chk("pp_w0", log_q.size() > 0 ? log_q[0] : 26'h3FFFFFF, {2'd0, 16'h0001, 8'h44});
    chk("pp_w1", log_q.size() > 1 ? log_q[1] : 26'h3FFFFFF, {2'd1, 16'h0002, 8'h55});
    chk("pp_w2", log_q.size() > 2 ? log_q[2] : 26'h3FFFFFF, {2'd2, 16'h0003, 8'h66});
    chk("pp_count", byte_count, 3);

    restart();
    mq.delete(); m_ovf = 1'b0; m_rng = 1'b0; m_cnt = 16'h0000;
    for (int i = 0; i < 400; i++) begin
      model_check();
      dn_wr = ($urandom % 3) != 0;
      dn_addr = ($urandom % 8 == 0) ? 16'(16'hFFFF - $urandom_range(0, 3)) : 16'($urandom_range(0, 16'h6200));
      dn_data = 8'($urandom);
      wr_ready = ($urandom % 2) != 0;
      model_step();
      tick();
    end
    dn_wr = 1'b0;
    wr_ready = 1'b1;
    repeat (4) begin model_check(); model_step(); tick(); end
    model_check();

    drain_to_hold();
    hold_len("final_hold");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
